mem_lsu_fmt: RTL
================

// Module: mem_lsu_fmt
// PURPOSE
//  MEM-stage load/store formatter and data-memory sequencer for the pipelined MIPS core.
//  Store path narrows 32-bit register data onto byte lanes: SB/SH/SW data plus byte enables.
//  Load path takes the selected lane from the memory word and zero/sign-extends it to 32 bits.
//  Sequences one access at a time against a variable-latency data memory (req/ack); busy stalls the pipeline.
// PARAMETERS
//  TIMEOUT    16                 max cycles waiting for mem_ack before bus_err (>=2)
//  TO_W       $clog2(TIMEOUT+1)  timeout counter width (derived; do not override)
// PORTS
//  clk          in   1   core clock, all state on rising edge
//  rstn         in   1   asynchronous active-low reset
//  req_valid    in   1   EX/MEM offers a load/store
//  req_ready    out  1   block accepts request (IDLE only)
//  req_we       in   1   1=store, 0=load
//  req_size     in   2   00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned in   1   loads only: 1=zero-extend (LBU/LHU), 0=sign-extend
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data (rt), LSBs significant
//  busy         out  1   pipeline stall: request held or in flight
//  rsp_valid    out  1   one-cycle completion pulse
//  rsp_rdata    out  32  extended load data, valid with rsp_valid (0 for stores)
//  misalign     out  1   one-cycle pulse: request rejected (alignment or illegal size)
//  bus_err      out  1   one-cycle pulse: mem_ack timeout
//  mem_req      out  1   memory request, held until mem_ack
//  mem_we       out  1   memory write
//  mem_be       out  4   byte enables, bit i = bits [8i+7:8i] (little-endian)
//  mem_addr     out  32  word address {req_addr[31:2],2'b00}
//  mem_wdata    out  32  lane-replicated store data
//  mem_ack      in   1   memory done; mem_rdata valid same cycle for loads
//  mem_rdata    in   32  memory read word
// BEHAVIOUR
//  Reset: state=IDLE, timeout counter=0, every output 0 except req_ready=1; applies immediately, any state.
//  FSM IDLE -> BUSY -> RESP -> IDLE.
//   IDLE: req_ready=1; busy=req_valid. Handshake = req_valid&req_ready; latch we/size/unsigned/addr/wdata.
//    Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size=11: misalign=1 next cycle, stay IDLE, no mem_req.
//    Otherwise -> BUSY.
//   BUSY: mem_req=1, busy=1, outputs stable. Counter increments each cycle without ack.
//    mem_ack=1: capture data -> RESP. Ack allowed on first BUSY cycle.
//    Counter reaching TIMEOUT without ack: drop mem_req, bus_err=1 next cycle, -> IDLE, no rsp_valid.
//   RESP: rsp_valid=1 for exactly one cycle, busy=0, counter cleared -> IDLE.
//  Latency: handshake at cycle 0, mem_req from cycle 1, ack at cycle k>=1, rsp_valid at cycle k+1.
//  mem_ack while not in BUSY is ignored.
//  Store formatting:
//   byte: be=4'b0001<<addr[1:0], wdata={4{d[7:0]}}
//   half: be=addr[1]?4'b1100:4'b0011, wdata={2{d[15:0]}}
//   word: be=4'b1111, wdata=d
//  Load extraction, ofs=addr[1:0]:
//   byte: b=rdata[8*ofs+:8]; out={{24{~uns&b[7]}},b}
//   half: h=addr[1]?rdata[31:16]:rdata[15:0]; out={{16{~uns&h[15]}},h}
//   word: rdata; req_unsigned ignored.
//  mem_be=0, mem_wdata=0 for loads; rsp_rdata=0 for stores.
//  misalign and bus_err never assert in the same cycle as rsp_valid.
// TESTING
//  SB addr=0x1003 wdata=0x000000AB -> mem_be=1000, mem_wdata=0xABABABAB, mem_addr=0x1000, rsp_valid one cycle after ack.
//  LB/LBU addr=0x1002 rdata=0x12803456 -> rsp_rdata=0xFFFFFF80 / 0x00000080.
//  LH addr=0x1001, and size=11 -> misalign pulse next cycle, mem_req never asserts, req_ready stays 1.
//  LW with ack on first BUSY cycle (rdata=0xDEADBEEF) -> rsp_valid at cycle 2 with 0xDEADBEEF; LHU addr=0x1002 rdata=0xBEEF0000 -> 0x0000BEEF.
//  No mem_ack for TIMEOUT=16 cycles -> mem_req drops, bus_err one cycle, no rsp_valid; next request accepted.
//  rstn low mid-BUSY -> mem_req=0, req_ready=1 immediately; later ack ignored; next SW completes normally.

Source files
------------

// File: rtl/mem_lsu_fmt.sv
// MEM-stage load/store formatter and single-outstanding data-memory sequencer.
// Stores are lane-replicated with byte enables; loads are lane-extracted and extended.
module mem_lsu_fmt #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        misalign,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t          state;
  logic [TO_W-1:0] cnt;
  logic            we_p1;
  logic [1:0]      size_p1;
  logic            uns_p1;
  logic [1:0]      ofs_p1;
  logic            bad_p0;

  function automatic logic [3:0] fmt_be(input logic [1:0] size, input logic [1:0] ofs);
    case (size)
      2'b00:   fmt_be = 4'b0001 << ofs;
      2'b01:   fmt_be = ofs[1] ? 4'b1100 : 4'b0011;
      default: fmt_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] fmt_wdata(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'b00:   fmt_wdata = {4{d[7:0]}};
      2'b01:   fmt_wdata = {2{d[15:0]}};
      default: fmt_wdata = d;
    endcase
  endfunction

  function automatic logic [31:0] ext_load(input logic [31:0] rdata, input logic [1:0] size,
                                           input logic uns, input logic [1:0] ofs);
    logic        [7:0]  b;
    logic        [15:0] h;
    logic signed [31:0] bs;
    logic signed [31:0] hs;
    b  = rdata[{ofs, 3'b000} +: 8];
    h  = ofs[1] ? rdata[31:16] : rdata[15:0];
    bs = 32'(signed'(b));
    hs = 32'(signed'(h));
    case (size)
      2'b00:   ext_load = uns ? {24'h0, b} : bs;
      2'b01:   ext_load = uns ? {16'h0, h} : hs;
      default: ext_load = rdata;
    endcase
  endfunction

  // Illegal size or a half/word that straddles its natural boundary is rejected in IDLE.
  assign bad_p0 = (req_size == 2'b11) ||
                  (req_size == 2'b01 && req_addr[0]) ||
                  (req_size == 2'b10 && req_addr[1:0] != 2'b00);

  assign busy = (state == S_IDLE) ? req_valid : (state == S_BUSY);

  // p0 -> p1: request attributes held for load extraction at ack time
  always_ff @(posedge clk) begin
    if (state == S_IDLE && req_valid) begin
      we_p1   <= req_we;
      size_p1 <= req_size;
      uns_p1  <= req_unsigned;
      ofs_p1  <= req_addr[1:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            if (bad_p0) begin
              misalign <= 1'b1;
            end else begin
              state     <= S_BUSY;
              req_ready <= 1'b0;
              cnt       <= '0;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_be    <= req_we ? fmt_be(req_size, req_addr[1:0]) : 4'b0000;
              mem_wdata <= req_we ? fmt_wdata(req_size, req_wdata) : 32'h0;
            end
          end
        end
        // p1 -> p2: memory word captured and extended on ack
        S_BUSY: begin
          if (mem_ack) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= we_p1 ? 32'h0 : ext_load(mem_rdata, size_p1, uns_p1, ofs_p1);
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
          end else if (cnt == TO_W'(TIMEOUT - 1)) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            bus_err   <= 1'b1;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
          end else begin
            cnt <= cnt + TO_W'(1);
          end
        end
        S_RESP: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          cnt       <= '0;
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
